// File: rtl/avalon_mm_cmd_master.sv
// Avalon-MM master stage: one valid/ready command in, one bus transfer, one valid/ready response out.
// Optional waitrequest timeout abort is compiled in with `define AVM_TIMEOUT_EN.
module avalon_mm_cmd_master #(
  parameter int DW             = 32,
  parameter int N              = DW / 8,
  parameter int AW             = 32,
  parameter int READ_LATENCY   = 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  input  logic [N-1:0]  cmd_byteenable,
  output logic [AW-1:0] address,
  output logic          read,
  output logic          write,
  output logic          chipselect,
  output logic [DW-1:0] writedata,
  output logic [N-1:0]  byteenable,
  input  logic          waitrequest,
  input  logic [DW-1:0] readdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_write,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err
);
  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT, RESP} state_t;

  localparam int LW            = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
  localparam bit RD_SAME_CYCLE = (READ_LATENCY == 0);

  state_t        state_reg;
  logic [LW-1:0] lat_cnt_reg;
  logic          timeout_hit;
  logic          issue_end;

`ifdef AVM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_reg;

  // Counts consecutive stalled cycles; any cycle outside ISSUE restarts it.
  assign timeout_hit = waitrequest && (to_cnt_reg == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || state_reg != ISSUE) begin
      to_cnt_reg <= '0;
    end else if (waitrequest) begin
      to_cnt_reg <= to_cnt_reg + TW'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign issue_end = ~waitrequest | timeout_hit;

  // The bus output registers double as the command holding registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      lat_cnt_reg <= '0;
      cmd_ready   <= 1'b0;
      address     <= '0;
      read        <= 1'b0;
      write       <= 1'b0;
      chipselect  <= 1'b0;
      writedata   <= '0;
      byteenable  <= '0;
      rsp_valid   <= 1'b0;
      rsp_write   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready  <= 1'b0;
            chipselect <= 1'b1;
            read       <= ~cmd_write;
            write      <= cmd_write;
            address    <= cmd_addr;
            writedata  <= cmd_wdata;
            byteenable <= cmd_byteenable;
            state_reg  <= ISSUE;
          end
        end
        ISSUE: begin
          if (issue_end) begin
            chipselect <= 1'b0;
            read       <= 1'b0;
            write      <= 1'b0;
            address    <= '0;
            writedata  <= '0;
            byteenable <= '0;
            rsp_write  <= write;
            rsp_err    <= timeout_hit;
            rsp_rdata  <= (read && RD_SAME_CYCLE && !timeout_hit) ? readdata : '0;
            if (write || timeout_hit || RD_SAME_CYCLE) begin
              rsp_valid <= 1'b1;
              state_reg <= RESP;
            end else begin
              lat_cnt_reg <= LW'(READ_LATENCY - 1);
              state_reg   <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (lat_cnt_reg == '0) begin
            rsp_rdata <= readdata;
            rsp_valid <= 1'b1;
            state_reg <= RESP;
          end else begin
            lat_cnt_reg <= lat_cnt_reg - LW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_avalon_mm_cmd_master.sv
// Bench for avalon_mm_cmd_master: memory slave with programmable stalls, transaction-level
// scoreboard checked every cycle, and directed scenarios with literal expectations.
module tb_avalon_mm_cmd_master;
  localparam int DW = 32;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int RL = 1;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [N-1:0]  cmd_byteenable = '0;
  logic [AW-1:0] address;
  logic          read;
  logic          write;
  logic          chipselect;
  logic [DW-1:0] writedata;
  logic [N-1:0]  byteenable;
  logic          waitrequest = 1'b0;
  logic [DW-1:0] readdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic          rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  always #5 clk = ~clk;

  avalon_mm_cmd_master #(
    .DW(DW), .N(N), .AW(AW), .READ_LATENCY(RL), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_byteenable(cmd_byteenable),
    .address(address), .read(read), .write(write), .chipselect(chipselect),
    .writedata(writedata), .byteenable(byteenable),
    .waitrequest(waitrequest), .readdata(readdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Shared observation state written by the scoreboard, read by the directed tests
  int          cyc = 0;
  int          stall_left = 0;
  int          rsp_count = 0;
  int          wr_cycles = 0;
  int          cs_cycles = 0;
  int          acc_log[$];
  logic [31:0] rd_log[$];
  logic        last_write;
  logic        last_err;
  logic [31:0] last_rdata;

  // Slave: memory with readdata one cycle after an accepted read, junk otherwise
  logic [31:0] slave_mem [256];
  initial begin
    logic       pend_rd, pend_wr;
    logic [7:0] pa;
    logic [31:0] pd;
    logic [3:0] pb;
    for (int i = 0; i < 256; i++) slave_mem[i] = '0;
    forever begin
      @(negedge clk);
      pend_rd = !reset && chipselect && read && !waitrequest;
      pend_wr = !reset && chipselect && write && !waitrequest;
      pa = address[7:0];
      pd = writedata;
      pb = byteenable;
      @(posedge clk);
      #1;
      if (pend_wr)
        for (int b = 0; b < 4; b++)
          if (pb[b]) slave_mem[pa][8*b +: 8] = pd[8*b +: 8];
      readdata = pend_rd ? slave_mem[pa] : (32'hBAD0_0000 | (cyc & 32'hFFFF));
      if (chipselect && stall_left > 0) begin
        waitrequest = 1'b1;
        stall_left--;
      end else begin
        waitrequest = 1'b0;
      end
    end
  end

  // Transaction-level scoreboard
  typedef struct packed {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    logic        xfer;
    logic        abort;
  } txn_t;

  txn_t        q[$];
  logic [31:0] model_mem [256];

  initial begin
    logic        rst_prev = 1'b0;
    logic        prev_hold = 1'b0;
    logic        prev_rsp_hold = 1'b0;
    logic        abort_pend = 1'b0;
    logic [31:0] prev_addr, prev_wdata;
    logic [6:0]  prev_ctl;
    logic [33:0] prev_rsp;
    int          wait_run = 0;
    txn_t        h;
    for (int i = 0; i < 256; i++) model_mem[i] = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_prev) begin
        chk("rst_ctrl", {cmd_ready, chipselect, read, write, rsp_valid, rsp_write, rsp_err}, 0);
        chk("rst_addr", address, 0);
        chk("rst_wdata_be", {writedata, byteenable}, 0);
        chk("rst_rdata", rsp_rdata, 0);
      end
      if (reset) begin
        q.delete();
        prev_hold = 1'b0;
        prev_rsp_hold = 1'b0;
        abort_pend = 1'b0;
        wait_run = 0;
        rst_prev = 1'b1;
        continue;
      end
      rst_prev = 1'b0;
      if (chipselect) cs_cycles++;
      if (write) wr_cycles++;

      chk("rw_exclusive", read && write, 0);
      chk("cs_matches_strobe", chipselect, read || write);
      chk("ready_only_idle", cmd_ready && (chipselect || rsp_valid), 0);

      if (abort_pend) chk("abort_drop_bus", chipselect, 0);
      else if (prev_hold) begin
        chk("hold_addr", address, prev_addr);
        chk("hold_wdata", writedata, prev_wdata);
        chk("hold_ctl", {byteenable, read, write, chipselect}, prev_ctl);
      end
      abort_pend = 1'b0;
      if (prev_rsp_hold) begin
        chk("rsp_hold_valid", rsp_valid, 1);
        chk("rsp_hold_fields", {rsp_write, rsp_err, rsp_rdata}, prev_rsp);
      end

      if (cmd_valid && cmd_ready) begin
        chk("one_outstanding", q.size(), 0);
        h.w = cmd_write;
        h.a = cmd_addr;
        h.d = cmd_wdata;
        h.be = cmd_byteenable;
        h.exp_rd = cmd_write ? 32'h0 : model_mem[cmd_addr[7:0]];
        h.xfer = 1'b0;
        h.abort = 1'b0;
        q.push_back(h);
        acc_log.push_back(cyc);
      end

      if (chipselect && !waitrequest) begin
        if (q.size() == 0 || q[0].xfer) chk("xfer_unexpected", 1, 0);
        else begin
          h = q[0];
          chk("xfer_write", write, h.w);
          chk("xfer_addr", address, h.a);
          if (h.w) begin
            chk("xfer_wdata", writedata, h.d);
            chk("xfer_be", byteenable, h.be);
          end
          h.xfer = 1'b1;
          q[0] = h;
        end
      end

`ifdef AVM_TIMEOUT_EN
      if (chipselect && waitrequest) begin
        wait_run++;
        if (wait_run == TO && q.size() > 0) begin
          h = q[0];
          h.abort = 1'b1;
          q[0] = h;
          abort_pend = 1'b1;
          wait_run = 0;
        end
      end else begin
        wait_run = 0;
      end
`endif

      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          h = q.pop_front();
          chk("rsp_after_xfer", h.xfer || h.abort, 1);
          chk("rsp_write", rsp_write, h.w);
          chk("rsp_err", rsp_err, h.abort);
          chk("rsp_rdata", rsp_rdata, (h.w || h.abort) ? 32'h0 : h.exp_rd);
          if (h.w && !h.abort)
            for (int b = 0; b < 4; b++)
              if (h.be[b]) model_mem[h.a[7:0]][8*b +: 8] = h.d[8*b +: 8];
          if (!h.w) rd_log.push_back(rsp_rdata);
          last_write = rsp_write;
          last_err = rsp_err;
          last_rdata = rsp_rdata;
          rsp_count++;
        end
      end

      prev_hold = chipselect && waitrequest;
      prev_addr = address;
      prev_wdata = writedata;
      prev_ctl = {byteenable, read, write, chipselect};
      prev_rsp_hold = rsp_valid && !rsp_ready;
      prev_rsp = {rsp_write, rsp_err, rsp_rdata};
    end
  end

  // Directed stimulus (all called at posedge+1)
  task automatic wait_accept();
    int n = 0;
    logic acc = 1'b0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = cmd_ready;
      @(posedge clk);
      #1;
      n++;
    end
    chk("cmd_accept", acc, 1);
  endtask

  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr = a;
    cmd_wdata = d;
    cmd_byteenable = be;
    wait_accept();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    int n = 0;
    while (rsp_count < target && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("rsp_arrival", rsp_count >= target, 1);
  endtask

  initial begin
    int   r0, c0, w0, base, rb, n;
    logic seen;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_cmd_ready", cmd_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("cmd_ready_before_edge", cmd_ready, 0);
    @(negedge clk);
    chk("cmd_ready_after_reset", cmd_ready, 1);
    @(posedge clk);
    #1;

    // T1: single write, no stall
    r0 = rsp_count;
    w0 = wr_cycles;
    send(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    wait_rsp(r0 + 1);
    chk("t1_write_cycles", wr_cycles - w0, 1);
    chk("t1_rsp_write", last_write, 1);
    chk("t1_rsp_err", last_err, 0);
    chk("t1_rsp_rdata", last_rdata, 32'h0);

    // T2: read with 3 stall cycles
    r0 = rsp_count;
    c0 = cs_cycles;
    stall_left = 3;
    send(1'b0, 32'h10, 32'h0, 4'h0);
    wait_rsp(r0 + 1);
    chk("t2_bus_cycles", cs_cycles - c0, 4);
    chk("t2_rsp_write", last_write, 0);
    chk("t2_rsp_rdata", last_rdata, 32'hDEADBEEF);

    // T3: response back-pressure with a command waiting
    r0 = rsp_count;
    rsp_ready = 1'b0;
    send(1'b1, 32'h20, 32'h12345678, 4'b0101);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr = 32'h20;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 50) begin
      @(negedge clk);
      seen = rsp_valid;
      @(posedge clk);
      #1;
      n++;
    end
    chk("t3_rsp_seen", seen, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_cmd_ready_low", cmd_ready, 0);
      chk("t3_rsp_valid_held", rsp_valid, 1);
      chk("t3_rsp_write_held", rsp_write, 1);
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    wait_accept();
    cmd_valid = 1'b0;
    wait_rsp(r0 + 2);
    chk("t3_rsp_count", rsp_count - r0, 2);
    chk("t3_masked_rdata", last_rdata, 32'h00340078);

    // T4: reset while stalled in ISSUE
    stall_left = 1000;
    send(1'b0, 32'h10, 32'h0, 4'h0);
    @(negedge clk);
    chk("t4_in_issue", {chipselect, read, waitrequest}, 3'b111);
    @(posedge clk);
    #1;
    r0 = rsp_count;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    stall_left = 0;
    @(negedge clk);
    chk("t4_bus_dropped", {chipselect, read, write}, 0);
    chk("t4_rsp_valid", rsp_valid, 0);
    chk("t4_cmd_ready_low", cmd_ready, 0);
    @(negedge clk);
    chk("t4_cmd_ready_back", cmd_ready, 1);
    @(posedge clk);
    #1;
    repeat (10) @(posedge clk);
    #1;
    chk("t4_no_rsp", rsp_count, r0);

`ifdef AVM_TIMEOUT_EN
    // T5: waitrequest stuck high -> abort
    r0 = rsp_count;
    c0 = cs_cycles;
    stall_left = 1000;
    send(1'b0, 32'h10, 32'h0, 4'h0);
    wait_rsp(r0 + 1);
    stall_left = 0;
    chk("t5_bus_cycles", cs_cycles - c0, 8);
    chk("t5_rsp_err", last_err, 1);
    chk("t5_rsp_rdata", last_rdata, 32'h0);
`endif

    // T6: 16 writes then 16 reads back to back
    r0 = rsp_count;
    base = acc_log.size();
    rb = rd_log.size();
    for (int i = 0; i < 16; i++) send(1'b1, 32'(i), 32'(i * 3), 4'hF);
    for (int i = 0; i < 16; i++) send(1'b0, 32'(i), 32'h0, 4'h0);
    wait_rsp(r0 + 32);
    repeat (5) @(posedge clk);
    #1;
    chk("t6_rsp_count", rsp_count - r0, 32);
    if (acc_log.size() >= base + 32) begin
      for (int k = 0; k < 31; k++)
        chk("t6_accept_gap", acc_log[base + k + 1] - acc_log[base + k], (k < 16) ? 3 : 4);
    end else chk("t6_accept_count", acc_log.size() - base, 32);
    if (rd_log.size() >= rb + 16) begin
      for (int i = 0; i < 16; i++) chk("t6_read_data", rd_log[rb + i], 32'(i * 3));
    end else chk("t6_read_count", rd_log.size() - rb, 16);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1, "watchdog");
  end
endmodule
